i2c_bus_monitor: RTL and testbench
==================================

# i2c_bus_monitor

Parametrised, fully synchronous I2C bus monitor and the successor to the asynchronous start/stop detector. It oversamples SDA/SCL on the system clock through a synchroniser and a glitch filter. On the filtered lines it detects START, repeated START and STOP, tracks bus-busy state, deserialises each byte with its ACK bit, and aborts a hung transfer after a programmable timeout. It is passive (never drives the bus) and feeds the slave/protocol logic downstream.

## Interface
- SYNC_STAGES, 2, synchroniser flops per line (≥2)
- FILT_LEN, 3, consecutive equal samples required to accept a line change (≥1)
- TIMEOUT_W, 16, timeout counter width
- TIMEOUT_CYC, 50000, clk cycles without any filtered SCL/SDA edge while busy before abort; 0 disables
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  monitor enable; low forces IDLE and suppresses all event outputs
- sda_in  in  1  raw SDA pin
- scl_in  in  1  raw SCL pin
- start  out  1  1-cycle pulse, START from idle
- rstart  out  1  1-cycle pulse, repeated START while busy
- stop  out  1  1-cycle pulse, STOP
- busy  out  1  bus busy (START seen, no STOP/timeout yet)
- byte_valid  out  1  1-cycle pulse, byte + ACK captured
- byte_data  out  8  last complete byte, MSB first on the wire
- ack_bit  out  1  9th bit of last byte (0 = ACK)
- first_byte  out  1  byte_data is the first byte after (r)START (address byte); valid with byte_valid
- bit_cnt  out  4  bits received in current frame, 0..8
- timeout  out  1  1-cycle pulse, timeout abort

## Operation
- Per line: SYNC_STAGES-flop chain, then filter. Filtered value takes the synced value on the edge where the FILT_LEN-th consecutive differing sample arrives. Any matching sample resets the run count.
- Edge detect compares filtered value with its 1-cycle-delayed copy. scl_rise/scl_fall/sda_rise/sda_fall are single-cycle strobes.
- START condition: sda_fall while filtered SCL high and no scl edge in the same cycle. STOP condition: sda_rise under the same rule.
- Simultaneous SCL and SDA filtered edges in one cycle: not START/STOP. If SCL rose, the new SDA value is the sampled bit.
- FSM IDLE/ACTIVE:
  - IDLE + START: pulse start, go to ACTIVE, bit_cnt=0, first_byte pending=1.
  - ACTIVE + START: pulse rstart, discard partial byte, bit_cnt=0, first_byte pending=1.
  - ACTIVE + STOP: pulse stop, go to IDLE, partial byte discarded, no byte_valid.
  - IDLE + STOP: pulse stop only.
- ACTIVE, scl_rise, bit_cnt<8: shift filtered SDA into shift register LSB, bit_cnt++.
- ACTIVE, scl_rise, bit_cnt==8: byte_data←shift register, ack_bit←SDA, first_byte←pending, then pending=0. Pulse byte_valid, bit_cnt←0.
- SCL edges in IDLE are ignored.
- Timeout counter: cleared on any filtered edge or in IDLE, increments otherwise, saturates at TIMEOUT_CYC. On reaching TIMEOUT_CYC in ACTIVE: pulse timeout, go to IDLE, bit_cnt=0, no byte_valid.
- en=0: synchronous force to IDLE, counters cleared, pulses held 0. Synchroniser and filters keep tracking, so re-enable causes no false event. byte_data/ack_bit/first_byte hold.

## Timing
- Reset values: sync/filtered lines 1 (bus idle), state IDLE, busy 0, all pulses 0, byte_data 0x00, ack_bit 1, first_byte 0, bit_cnt 0, timeout counter 0.
- Latency from a clean pin change (setup to edge k) to the filtered change: edge k+SYNC_STAGES+FILT_LEN−1.
- Event outputs are registered and appear 1 cycle after the filtered edge.
- busy rises with start, falls with stop/timeout.
- Pulses shorter than FILT_LEN samples after synchronisation are rejected.
- Minimum SCL high/low time for correct capture: FILT_LEN+2 clk cycles.
- rst_n assertion mid-byte: immediate return to reset values, no pulse emitted.

## Test plan
- Clean write 0xA4 + ACK, default params: start pulse, byte_valid with byte_data=0xA4, ack_bit=0, first_byte=1, then stop. busy high from start to stop.
- Two bytes 0x3C/NACK then 0x5A/ACK: second byte_valid has byte_data=0x5A, ack_bit=0, first_byte=0. First has ack_bit=1.
- Repeated START after 4 bits of a byte: rstart pulse, no byte_valid for the partial byte, bit_cnt=0. Next byte flagged first_byte=1. busy stays 1.
- Glitch injection: 2-cycle SDA low pulse while SCL high (FILT_LEN=3) yields no start. A 3-cycle pulse yields start exactly SYNC_STAGES+FILT_LEN cycles after the pin edge.
- TIMEOUT_CYC=100: START then SCL held low. timeout pulse after 100 idle cycles, busy 0. A subsequent STOP gives stop only.
- en low during a transfer then high mid-byte: no pulses while low, IDLE on re-enable, bits ignored until next START. rst_n pulse mid-byte returns every output to its reset value.

Source files
------------

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronises and filters SDA/SCL, detects
// START/rSTART/STOP, deserialises bytes with ACK and aborts hung transfers.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       start,
    output logic       rstart,
    output logic       stop,
    output logic       busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ack_bit,
    output logic       first_byte,
    output logic [3:0] bit_cnt,
    output logic       timeout
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(FILT_LEN - 1);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] TO_SAT  = TIMEOUT_W'(TIMEOUT_CYC);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [1:0]             line_s;
    logic [1:0]             filt;
    logic [1:0]             filt_d;
    logic [CW-1:0]          run [2];
    logic [7:0]             shift;
    logic                   pending;
    logic [TIMEOUT_W-1:0]   to_cnt;

    logic sda_f;
    logic scl_f;
    logic scl_rise;
    logic scl_edge;
    logic sda_rise;
    logic sda_fall;
    logic sda_edge;
    logic any_edge;
    logic start_cond;
    logic stop_cond;
    logic to_hit;

    // Metastability chains; reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_sync <= '1;
            scl_sync <= '1;
        end else begin
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
        end
    end

    // Index 0 is SDA, index 1 is SCL
    assign line_s = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

    // Glitch filter: accept a change after FILT_LEN differing samples in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt   <= 2'b11;
            filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                run[i] <= '0;
            end
        end else begin
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (line_s[i] != filt[i]) begin
                    if (run[i] == RUN_LAST) begin
                        filt[i] <= line_s[i];
                        run[i]  <= '0;
                    end else begin
                        run[i] <= run[i] + 1'b1;
                    end
                end else begin
                    run[i] <= '0;
                end
            end
        end
    end

    assign sda_f    = filt[0];
    assign scl_f    = filt[1];
    assign scl_rise = scl_f & ~filt_d[1];
    assign scl_edge = scl_f ^ filt_d[1];
    assign sda_rise = sda_f & ~filt_d[0];
    assign sda_fall = ~sda_f & filt_d[0];
    assign sda_edge = sda_f ^ filt_d[0];
    assign any_edge = scl_edge | sda_edge;

    // SDA moving while SCL is steadily high marks a bus condition
    assign start_cond = sda_fall & scl_f & ~scl_edge;
    assign stop_cond  = sda_rise & scl_f & ~scl_edge;
    assign to_hit     = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST) && !any_edge;

    // Protocol FSM with byte deserialiser and inactivity timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            start      <= 1'b0;
            rstart     <= 1'b0;
            stop       <= 1'b0;
            byte_valid <= 1'b0;
            timeout    <= 1'b0;
            byte_data  <= 8'h00;
            ack_bit    <= 1'b1;
            first_byte <= 1'b0;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            pending    <= 1'b0;
            to_cnt     <= '0;
        end else begin
            start      <= 1'b0;
            rstart     <= 1'b0;
            stop       <= 1'b0;
            byte_valid <= 1'b0;
            timeout    <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
                pending <= 1'b0;
                to_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        to_cnt <= '0;
                        if (start_cond) begin
                            start   <= 1'b1;
                            state   <= ACTIVE;
                            busy    <= 1'b1;
                            bit_cnt <= 4'd0;
                            pending <= 1'b1;
                        end else if (stop_cond) begin
                            stop <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (any_edge) begin
                            to_cnt <= '0;
                        end else if (to_cnt != TO_SAT) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                        if (start_cond) begin
                            rstart  <= 1'b1;
                            bit_cnt <= 4'd0;
                            pending <= 1'b1;
                        end else if (stop_cond) begin
                            stop    <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                            bit_cnt <= 4'd0;
                        end else if (to_hit) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                            bit_cnt <= 4'd0;
                        end else if (scl_rise) begin
                            if (bit_cnt == 4'd8) begin
                                byte_data  <= shift;
                                ack_bit    <= sda_f;
                                first_byte <= pending;
                                pending    <= 1'b0;
                                byte_valid <= 1'b1;
                                bit_cnt    <= 4'd0;
                            end else begin
                                shift   <= {shift[6:0], sda_f};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: default instance plus a
// short-timeout instance sharing the same pins.
module tb_i2c_bus_monitor;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic sda = 1'b1;
    logic scl = 1'b1;

    logic       start, rstart, stop, busy, byte_valid;
    logic [7:0] byte_data;
    logic       ack_bit, first_byte, timeout;
    logic [3:0] bit_cnt;

    logic       t_start, t_rstart, t_stop, t_busy, t_byte_valid;
    logic [7:0] t_byte_data;
    logic       t_ack_bit, t_first_byte, t_timeout;
    logic [3:0] t_bit_cnt;

    i2c_bus_monitor dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .sda_in(sda), .scl_in(scl),
        .start(start), .rstart(rstart), .stop(stop), .busy(busy),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .ack_bit(ack_bit), .first_byte(first_byte),
        .bit_cnt(bit_cnt), .timeout(timeout)
    );

    i2c_bus_monitor #(.TIMEOUT_CYC(100)) dut_to (
        .clk(clk), .rst_n(rst_n), .en(en),
        .sda_in(sda), .scl_in(scl),
        .start(t_start), .rstart(t_rstart), .stop(t_stop), .busy(t_busy),
        .byte_valid(t_byte_valid), .byte_data(t_byte_data),
        .ack_bit(t_ack_bit), .first_byte(t_first_byte),
        .bit_cnt(t_bit_cnt), .timeout(t_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_start = 0, n_rstart = 0, n_stop = 0, n_bv = 0, n_to = 0;
    int m_start = 0, m_rstart = 0, m_stop = 0, m_bv = 0, m_to = 0;
    logic [7:0] cap_data [$];
    logic       cap_ack [$];
    logic       cap_first [$];

    // Event recorder, sampled away from the active edge
    always @(negedge clk) begin
        if (start) n_start++;
        if (rstart) n_rstart++;
        if (stop) n_stop++;
        if (timeout) n_to++;
        if (byte_valid) begin
            n_bv++;
            cap_data.push_back(byte_data);
            cap_ack.push_back(ack_bit);
            cap_first.push_back(first_byte);
        end
        if (t_start) m_start++;
        if (t_rstart) m_rstart++;
        if (t_stop) m_stop++;
        if (t_byte_valid) m_bv++;
        if (t_timeout) m_to++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_start();
        sda = 1'b0; cyc(H);
        scl = 1'b0; cyc(H);
    endtask

    task automatic send_bit(input logic b);
        sda = b;    cyc(H);
        scl = 1'b1; cyc(H);
        scl = 1'b0; cyc(H);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(a);
    endtask

    task automatic send_stop();
        sda = 1'b0; cyc(H);
        scl = 1'b1; cyc(H);
        sda = 1'b1; cyc(H);
    endtask

    task automatic send_rstart();
        sda = 1'b1; cyc(H);
        scl = 1'b1; cyc(H);
        sda = 1'b0; cyc(H);
        scl = 1'b0; cyc(H);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, p0, v0, t0;
        int lat;
        logic seen;

        // reset values
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_byte_data", byte_data, 8'h00);
        chk("rst_ack", ack_bit, 1);
        chk("rst_first", first_byte, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_pulses", {start, rstart, stop, byte_valid, timeout}, 0);
        rst_n = 1'b1;
        cyc(10);

        // clean write 0xA4 + ACK
        s0 = n_start; p0 = n_stop; v0 = n_bv;
        send_start();
        chk("w1_start", n_start - s0, 1);
        chk("w1_busy_on", busy, 1);
        send_byte(8'hA4, 1'b0);
        chk("w1_bv_cnt", n_bv - v0, 1);
        chk("w1_data", cap_data[v0], 8'hA4);
        chk("w1_ack", cap_ack[v0], 0);
        chk("w1_first", cap_first[v0], 1);
        chk("w1_busy_mid", busy, 1);
        send_stop();
        chk("w1_stop", n_stop - p0, 1);
        chk("w1_busy_off", busy, 0);
        chk("w1_bv_after", n_bv - v0, 1);
        cyc(10);

        // two bytes: 0x3C/NACK, 0x5A/ACK
        v0 = n_bv;
        send_start();
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b0);
        send_stop();
        chk("w2_bv_cnt", n_bv - v0, 2);
        chk("w2_data0", cap_data[v0], 8'h3C);
        chk("w2_ack0", cap_ack[v0], 1);
        chk("w2_first0", cap_first[v0], 1);
        chk("w2_data1", cap_data[v0+1], 8'h5A);
        chk("w2_ack1", cap_ack[v0+1], 0);
        chk("w2_first1", cap_first[v0+1], 0);
        cyc(10);

        // repeated START after 4 bits
        s0 = n_start; r0 = n_rstart; v0 = n_bv;
        send_start();
        send_byte(8'h91, 1'b0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        chk("rs_bit_cnt4", bit_cnt, 4);
        send_rstart();
        chk("rs_rstart", n_rstart - r0, 1);
        chk("rs_start", n_start - s0, 1);
        chk("rs_no_bv", n_bv - v0, 1);
        chk("rs_bit_cnt0", bit_cnt, 0);
        chk("rs_busy", busy, 1);
        send_byte(8'h6E, 1'b1);
        chk("rs_bv_cnt", n_bv - v0, 2);
        chk("rs_data", cap_data[v0+1], 8'h6E);
        chk("rs_ack", cap_ack[v0+1], 1);
        chk("rs_first", cap_first[v0+1], 1);
        send_stop();
        cyc(10);

        // 2-sample SDA glitch while SCL high: rejected
        s0 = n_start;
        sda = 1'b0; cyc(2);
        sda = 1'b1; cyc(20);
        chk("gl2_no_start", n_start - s0, 0);
        chk("gl2_busy", busy, 0);

        // 3-sample glitch: start 5 edges after the first sampling edge
        sda = 1'b0;
        lat = -1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (start && !seen) begin
                seen = 1'b1;
                lat = i;
            end
            if (i == 2) begin
                @(negedge clk);
                sda = 1'b1;
            end
        end
        chk("gl3_latency", lat, 5);
        cyc(10);
        chk("gl3_busy_after_stop", busy, 0);

        // timeout on the 100-cycle instance: START, then SCL held low
        chk("to_idle", t_busy, 0);
        sda = 1'b0; cyc(H);
        chk("to_busy_on", t_busy, 1);
        scl = 1'b0;
        lat = -1;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (t_timeout && !seen) begin
                seen = 1'b1;
                lat = i;
            end
        end
        // 4 edges to filtered fall, 1 to clear, 100 counted
        chk("to_latency", lat, 105);
        chk("to_busy_off", t_busy, 0);
        chk("to_bit_cnt", t_bit_cnt, 0);
        chk("to_default_busy", busy, 1);
        chk("to_default_no_to", n_to, 0);
        s0 = m_start; r0 = m_rstart; p0 = m_stop; v0 = m_bv; t0 = m_to;
        @(negedge clk);
        scl = 1'b1; cyc(H);
        sda = 1'b1; cyc(H);
        chk("to_stop", m_stop - p0, 1);
        chk("to_stop_only",
            (m_start - s0) + (m_rstart - r0) + (m_bv - v0) + (m_to - t0), 0);
        cyc(10);

        // enable dropped mid-byte, restored mid-byte
        s0 = n_start; r0 = n_rstart; p0 = n_stop; v0 = n_bv; t0 = n_to;
        send_start();
        send_bit(1); send_bit(0); send_bit(1);
        chk("en_bit_cnt3", bit_cnt, 3);
        en = 1'b0;
        cyc(2);
        chk("en_busy_off", busy, 0);
        chk("en_bit_cnt0", bit_cnt, 0);
        send_bit(1); send_bit(1); send_bit(0);
        chk("en_low_pulses",
            (n_rstart - r0) + (n_stop - p0) + (n_bv - v0) + (n_to - t0), 0);
        en = 1'b1;
        send_bit(0); send_bit(1); send_bit(0);
        chk("en_ignored_bv", n_bv - v0, 0);
        chk("en_ignored_cnt", bit_cnt, 0);
        chk("en_hold_data", byte_data, 8'h6E);
        chk("en_hold_ack", ack_bit, 1);
        chk("en_hold_first", first_byte, 1);
        send_stop();
        chk("en_idle_stop", n_stop - p0, 1);
        cyc(10);
        send_start();
        send_byte(8'hC3, 1'b0);
        send_stop();
        chk("en_recover_cnt", n_bv - v0, 1);
        chk("en_recover_data", cap_data[v0], 8'hC3);
        chk("en_recover_first", cap_first[v0], 1);
        cyc(10);

        // asynchronous reset mid-byte
        send_start();
        send_bit(1); send_bit(1); send_bit(0); send_bit(1);
        chk("rm_bit_cnt4", bit_cnt, 4);
        rst_n = 1'b0;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_bit_cnt", bit_cnt, 0);
        chk("rm_data", byte_data, 8'h00);
        chk("rm_ack", ack_bit, 1);
        chk("rm_first", first_byte, 0);
        chk("rm_pulses", {start, rstart, stop, byte_valid, timeout}, 0);
        cyc(2);
        scl = 1'b1; cyc(2);
        sda = 1'b1; cyc(5);
        s0 = n_start; p0 = n_stop;
        rst_n = 1'b1;
        cyc(20);
        chk("rm_quiet", (n_start - s0) + (n_stop - p0), 0);
        chk("rm_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
